// File: rtl/acc_pkg.sv
// Shared constants for the accumulator/sequencer: datapath width, opcodes,
// FSM state encoding and the MUL iteration count.
package acc_pkg;

  localparam int WIDTH      = 8;
  localparam int MUL_CYCLES = 8;
  localparam int CNT_W      = 3;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_MUL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Two's-complement negate, mod 2^WIDTH; feeds the adder for SUB.
  function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] v);
    return (~v) + WIDTH'(1);
  endfunction

endpackage

// File: rtl/acc_flags.sv
// Carry/borrow and signed-overflow flags for one ADD or SUB step through the
// external adder. LOAD and MUL report C=V=0.
module acc_flags
  import acc_pkg::*;
(
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] operand,
  output logic             carry,
  output logic             ovf
);

  logic signed [WIDTH:0] ssum;

  always_comb begin
    ssum  = $signed({a[WIDTH-1], a}) + $signed({b[WIDTH-1], b});
    carry = 1'b0;
    ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        // The wrapped sum falls below an addend exactly when a carry left the MSB.
        carry = (c < a);
        ovf   = (ssum[WIDTH] != ssum[WIDTH-1]);
      end
      OP_SUB: begin
        carry = (a < operand);
        ovf   = (a[WIDTH-1] != operand[WIDTH-1]) && (c[WIDTH-1] != a[WIDTH-1]);
      end
      default: begin
        carry = 1'b0;
        ovf   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/acc_seq_unit.sv
// Accumulator/sequencer wrapped around an external 8-bit adder: LOAD/ADD/SUB
// in one cycle, shift-add MUL in 8. Define ACC_SAT_EN to saturate ADD/SUB on overflow.
module acc_seq_unit #(
  parameter int WIDTH = acc_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_c
);

  import acc_pkg::*;

  state_e             state, state_nxt;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   operand_q;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   prod, mcand, mplier;
  logic [CNT_W-1:0]   cnt;
  logic               cmd_hs;
  logic               mul_last;
  logic               exec_c, exec_v;
  logic [WIDTH-1:0]   exec_raw, exec_val;

`ifdef ACC_SAT_EN
  function automatic logic [WIDTH-1:0] sat_val(input logic [WIDTH-1:0] pre_acc);
    return pre_acc[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction
`endif

  assign cmd_hs   = in_valid & in_ready;
  assign mul_last = (cnt == CNT_W'(MUL_CYCLES - 1));
  assign result   = acc;

  acc_flags u_flags (
    .op      (op_q),
    .a       (acc),
    .b       (add_b),
    .c       (add_c),
    .operand (operand_q),
    .carry   (exec_c),
    .ovf     (exec_v)
  );

  always_comb begin
    exec_raw = (op_q == OP_LOAD) ? operand_q : add_c;
    exec_val = exec_raw;
`ifdef ACC_SAT_EN
    if (exec_v && ((op_q == OP_ADD) || (op_q == OP_SUB)))
      exec_val = sat_val(acc);
`endif
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (cmd_hs) state_nxt = (in_op == OP_MUL) ? S_MUL : S_EXEC;
      S_EXEC: state_nxt = S_DONE;
      S_MUL:  if (mul_last) state_nxt = S_DONE;
      S_DONE: if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs: handshake signals and adder operands; the adder idles at 0+0
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
    add_a     = '0;
    add_b     = '0;
    case (state)
      S_EXEC: begin
        if (op_q == OP_ADD) begin
          add_a = acc;
          add_b = operand_q;
        end else if (op_q == OP_SUB) begin
          add_a = acc;
          add_b = neg2c(operand_q);
        end
      end
      S_MUL: begin
        add_a = prod;
        add_b = mplier[0] ? mcand : '0;
      end
      default: begin
        add_a = '0;
        add_b = '0;
      end
    endcase
  end

  // Datapath: command latch, MUL work registers, accumulator and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= OP_LOAD;
      operand_q <= '0;
      acc       <= '0;
      prod      <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_hs) begin
            op_q      <= in_op;
            operand_q <= in_data;
            prod      <= '0;
            mcand     <= acc;
            mplier    <= in_data;
            cnt       <= '0;
          end
        end
        S_EXEC: begin
          acc    <= exec_val;
          flag_z <= (exec_val == '0);
          flag_n <= exec_val[WIDTH-1];
          flag_c <= exec_c;
          flag_v <= exec_v;
        end
        S_MUL: begin
          prod   <= add_c;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (mul_last) begin
            acc    <= add_c;
            flag_z <= (add_c == '0);
            flag_n <= add_c[WIDTH-1];
            flag_c <= 1'b0;
            flag_v <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/acc_seq_unit.md
Name: acc_seq_unit

Overview:
- Accumulator/sequencer that drives the operands of the team's 8-bit combinational adder and registers its sum.
- Sits directly around the adder: upstream as the operand source (add_a/add_b), downstream as the result consumer (add_c).
- Provides LOAD/ADD/SUB in one cycle and an 8-cycle shift-add MUL that reuses the same adder.
- Valid/ready handshake on command input and result output; status flags Z/N/C/V.

Parameters:
- WIDTH, 8, datapath width. Must equal the external adder width; only 8 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  command valid.
- in_ready  out  1  unit can accept a command; high only in IDLE.
- in_op  in  2  opcode: 00 LOAD, 01 ADD, 10 SUB, 11 MUL.
- in_data  in  WIDTH  operand.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  accumulator value.
- flag_z, flag_n, flag_c, flag_v  out  1 each  zero, negative, carry/borrow, signed overflow.
- add_a  out  WIDTH  adder operand A.
- add_b  out  WIDTH  adder operand B.
- add_c  in  WIDTH  adder sum, combinational from add_a/add_b.

Behaviour:
- Reset (async, any state including mid-MUL):
  - state=IDLE, acc=0, all flags=0, out_valid=0.
  - add_a=0, add_b=0; MUL work registers cleared.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready at an edge, latch op and operand. LOAD/ADD/SUB go to EXEC; MUL goes to MUL with cnt=0.
  - EXEC (one cycle): drive the adder and capture add_c at the next edge. Update acc and flags, then go to DONE.
  - MUL (8 cycles): see the MUL bullet. After cnt=7, update acc, then go to DONE.
  - DONE: out_valid=1, result/flags stable. On out_ready go to IDLE. No new command is accepted until the cycle after the out handshake.
- Latency from command handshake edge to out_valid: 1 cycle for LOAD/ADD/SUB, 8 cycles for MUL.
- Adder operands:
  - In IDLE and DONE, add_a=add_b=0.
  - ADD: add_a=acc, add_b=operand.
  - SUB: add_a=acc, add_b=(~operand)+1, mod 256. The negate is done locally.
  - LOAD: adder unused, acc<=operand.
- MUL (low 8 bits of an unsigned product):
  - Work registers: prod=0, mcand=acc, mplier=operand.
  - Each cycle: add_a=prod; add_b = mplier[0] ? mcand : 0; prod<=add_c; mcand<<=1; mplier>>=1.
  - Final acc=prod.
- Flags:
  - Z = (new acc == 0); N = new acc[7].
  - ADD: C = (a7&b7)|((a7|b7)&~c7); V = (a7==b7)&&(c7!=a7).
  - SUB: C = borrow = (acc < operand, unsigned); V = (acc[7]!=operand[7])&&(c7!=acc[7]).
  - LOAD and MUL: C=0, V=0.
- Wrap-around: all arithmetic is mod 256 (0xFF+0x01 -> 0x00, C=1, Z=1).
- Handshakes:
  - in_valid asserted outside IDLE is ignored and not queued.
  - out_valid deasserts the cycle after the out handshake.

Optional Feature:
- ACC_SAT_EN defined: for ADD/SUB with V=1, acc saturates:
  - acc (pre-op) non-negative -> 0x7F; acc negative -> 0x80.
  - V stays 1; Z/N are computed from the saturated value.
- ACC_SAT_EN undefined: wrap-around result. MUL is never saturated.

Decomposition:
- Package acc_pkg: WIDTH constant, opcode localparams (OP_LOAD/ADD/SUB/MUL), state encoding (IDLE/EXEC/MUL/DONE), MUL_CYCLES=8.
- One combinational sub-module acc_flags: inputs op, a, b, c, operand; outputs C and V.
- The adder remains an external instance wired through add_a/add_b/add_c.

Test Plan:
- Reset, then LOAD 0x05, then ADD 0x03 -> result=0x08 one cycle after the handshake; Z=N=C=V=0.
- Acc=0xFF, ADD 0x01 -> result=0x00, Z=1, C=1, V=0.
- Acc=0x7F, ADD 0x01 -> without ACC_SAT_EN: 0x80, N=1, V=1. With ACC_SAT_EN: 0x7F, V=1.
- Acc=0x03, SUB 0x05 -> 0xFE, N=1, C=1 (borrow), V=0. Acc=0x80, SUB 0x01 -> 0x7F, V=1.
- Acc=0x06, MUL 0x07 -> 0x2A after exactly 8 cycles, in_ready=0 throughout. Acc=0x10, MUL 0x10 -> 0x00, Z=1.
- Assert rst at MUL cycle 4 -> immediately acc=0, out_valid=0, in_ready=1.
- Hold out_ready=0 for 5 cycles in DONE -> result stable and in_valid ignored. Release -> IDLE the next cycle.
